// File: rtl/fme_pkg.sv
// Shared constants and FSM state type for the FME window loader.
// The loader always assembles FME_ROWS rows of FME_ROWLEN samples.
package fme_pkg;

  localparam int FME_ROWS           = 3;
  localparam int FME_ROWLEN         = 9;
  localparam int FME_WINDOW_SAMPLES = FME_ROWS * FME_ROWLEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } fme_state_e;

endpackage

// File: rtl/fme_row_reg.sv
// One candidate row: ROWLEN samples of DATAWIDTH bits.
// A single sample is written per cycle at position idx when we is high.
module fme_row_reg
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWLEN    = FME_ROWLEN,
  parameter int IW        = $clog2(ROWLEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [IW-1:0]               idx,
  input  logic [DATAWIDTH-1:0]        din,
  output logic [ROWLEN*DATAWIDTH-1:0] row
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
    end else begin
      for (int k = 0; k < ROWLEN; k++) begin
        if (we && (idx == IW'(k))) begin
          row[k*DATAWIDTH +: DATAWIDTH] <= din;
        end
      end
    end
  end

endmodule

// File: rtl/fme_window_loader.sv
// Fills rows a/b/c from a raster-ordered sample stream and holds the
// finished window with window_valid until the consumer acknowledges it.
module fme_window_loader
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWLEN    = FME_ROWLEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DATAWIDTH-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ROWLEN*DATAWIDTH-1:0] row_a,
  output logic [ROWLEN*DATAWIDTH-1:0] row_b,
  output logic [ROWLEN*DATAWIDTH-1:0] row_c,
  output logic                        window_valid,
  input  logic                        window_ack,
  output logic                        busy,
  output logic [4:0]                  sample_cnt,
  output logic [1:0]                  dbg_state
);

  localparam int CW = $clog2(ROWLEN);
  localparam logic [4:0] LAST_CNT = 5'(FME_ROWS * ROWLEN - 1);

  fme_state_e    state;
  logic [1:0]    row_idx;
  logic [CW-1:0] col_idx;
  logic          beat;
  logic          wr;

  // Stream handshake: a sample transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high for exactly the LOAD state.
  assign beat      = in_valid && in_ready;
  // An aborted beat completes the handshake but never reaches the rows.
  assign wr        = beat && !abort;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      window_valid <= 1'b0;
      sample_cnt   <= '0;
      row_idx      <= '0;
      col_idx      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            sample_cnt <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            sample_cnt <= '0;
          end else if (beat) begin
            sample_cnt <= sample_cnt + 5'd1;
            if (col_idx == CW'(ROWLEN - 1)) begin
              col_idx <= '0;
              row_idx <= row_idx + 2'd1;
            end else begin
              col_idx <= col_idx + CW'(1);
            end
            if (sample_cnt == LAST_CNT) begin
              state        <= ST_DONE;
              window_valid <= 1'b1;
              in_ready     <= 1'b0;
              busy         <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (window_ack) begin
            window_valid <= 1'b0;
            if (start) begin
              state      <= ST_LOAD;
              in_ready   <= 1'b1;
              busy       <= 1'b1;
              sample_cnt <= '0;
              row_idx    <= '0;
              col_idx    <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fme_row_reg #(.DATAWIDTH(DATAWIDTH), .ROWLEN(ROWLEN)) u_row_a (
    .clk(clk), .rst_n(rst_n), .we(wr && (row_idx == 2'd0)),
    .idx(col_idx), .din(in_data), .row(row_a)
  );

  fme_row_reg #(.DATAWIDTH(DATAWIDTH), .ROWLEN(ROWLEN)) u_row_b (
    .clk(clk), .rst_n(rst_n), .we(wr && (row_idx == 2'd1)),
    .idx(col_idx), .din(in_data), .row(row_b)
  );

  fme_row_reg #(.DATAWIDTH(DATAWIDTH), .ROWLEN(ROWLEN)) u_row_c (
    .clk(clk), .rst_n(rst_n), .we(wr && (row_idx == 2'd2)),
    .idx(col_idx), .din(in_data), .row(row_c)
  );

endmodule

// File: doc/fme_window_loader.md
Name: fme_window_loader

Overview:
- Writer side of the FME best-candidate select mux: assembles the three 9-sample candidate rows (a, b, c) that the mux reads.
- Samples arrive on a valid/ready stream in raster order: row a 0..8, row b 0..8, row c 0..8.
- The block holds the window stable with window_valid until the consumer acknowledges it.

Parameters:
- DATAWIDTH, 8, bits per sample.
- ROWLEN, 9, samples per row (fixed at 9 for the mux; parameterised for the counter only).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin loading a new window.
- abort  input  1  discard the partial load and return to IDLE.
- in_data  input  DATAWIDTH  incoming sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a sample this cycle.
- row_a  output  ROWLEN*DATAWIDTH  row a; sample k at [k*DATAWIDTH +: DATAWIDTH]; split to a0..a8 at instantiation.
- row_b  output  ROWLEN*DATAWIDTH  row b, same packing.
- row_c  output  ROWLEN*DATAWIDTH  row c, same packing.
- window_valid  output  1  all 3*ROWLEN samples loaded and stable.
- window_ack  input  1  consumer has taken the window.
- busy  output  1  high in LOAD.
- sample_cnt  output  5  samples accepted in the current load, 0..27.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; row_a/b/c=0; in_ready=0; window_valid=0; busy=0; sample_cnt=0. Reset mid-load drops all partial data.
- States: IDLE, LOAD, DONE. All outputs are registered.
- IDLE:
  - start=1 -> LOAD next cycle; in_ready=1 and busy=1 from that cycle; sample_cnt cleared to 0.
  - Row registers keep their old contents until overwritten.
- LOAD:
  - A beat is accepted when in_valid && in_ready.
  - Each accepted beat writes in_data to row[row_idx] sample col_idx, where row_idx 0..2 maps to a/b/c and col_idx runs 0..ROWLEN-1.
  - After each beat: col_idx increments; at ROWLEN-1 it wraps to 0 and row_idx increments. sample_cnt increments.
  - in_valid=0 stalls with no state change.
  - When beat 27 (row c, col 8) is accepted at cycle N: at N+1 state=DONE, window_valid=1, in_ready=0, busy=0, sample_cnt=27.
  - start in LOAD is ignored.
  - abort=1 -> IDLE next cycle: in_ready=0, busy=0, window_valid stays 0, sample_cnt=0. Abort has priority over a beat accepted in the same cycle; that beat is still consumed by the handshake but discarded.
- DONE:
  - row_a/b/c held stable.
  - window_ack=1 -> next cycle window_valid=0 and state=IDLE.
  - window_ack=1 and start=1 in the same cycle -> next cycle LOAD directly: window_valid=0, in_ready=1, sample_cnt=0.
  - start without ack is ignored.
  - abort in DONE is ignored; the window is only released by ack.
- window_ack outside DONE is ignored. abort outside LOAD is ignored.
- Throughput: at best 1 sample/cycle. A full window takes 27 cycles of LOAD plus 1 cycle to DONE.
- in_data is stored unmodified; no width conversion.

Decomposition:
- Shared package fme_pkg:
  - state enum (IDLE, LOAD, DONE);
  - FME_ROWS=3;
  - FME_ROWLEN=9;
  - FME_WINDOW_SAMPLES=27.
- One sub-module, fme_row_reg: ROWLEN x DATAWIDTH register with write-enable and index, instantiated three times.
- Counter/FSM stays in the top level.

Test Plan:
- Reset mid-load: start, accept 5 beats, pull rst_n low -> all rows 0, in_ready=0, sample_cnt=0 immediately (asynchronous).
- Full load, no stalls: start, then in_valid held high with data 0x01..0x1B -> row_a=0x09..0x01 (a0=0x01, a8=0x09), b0=0x0A, c8=0x1B; window_valid rises exactly 1 cycle after beat 27; in_ready=0 in the same cycle.
- Stalls: drive the same 27 values with in_valid toggling every other cycle -> identical row contents; sample_cnt tracks accepted beats only; no beat is lost or duplicated.
- Abort: abort at sample_cnt=13 together with a valid beat 0xFF -> IDLE next cycle, window_valid stays 0. A restart with 0x20..0x3A loads a0=0x20 with no residue from the aborted load.
- Hold and ack: in DONE, hold window_ack=0 for 10 cycles while toggling start and abort -> rows and window_valid unchanged. Then ack=1 -> window_valid=0 next cycle and state IDLE.
- Back-to-back: ack=1 and start=1 in the same cycle -> next cycle in_ready=1, sample_cnt=0, window_valid=0. The second window of 0x40..0x5A fully replaces the rows (c8=0x5A).
